// File: rtl/pygmy_cfg.sv
`default_nettype none
// ============================================================================
// Package     : pygmy_cfg
// Description : Build-time configuration for the USB request scheduler.
//               USB_ROB_TID_W     - tracking-table index width (2**W entries)
//               USB_ROB_MAX_OUTST - outstanding transactions per requester
// Revision    : 1.0 - initial release
// ============================================================================
package pygmy_cfg;
    localparam int USB_ROB_TID_W     = 4;
    localparam int USB_ROB_MAX_OUTST = 4;
endpackage : pygmy_cfg
`default_nettype wire

// File: rtl/pygmy_intf_typedef.sv
`default_nettype none
// ============================================================================
// Package     : pygmy_intf_typedef
// Description : CPU <-> cache interface payload types and the scheduler's
//               tracking-table entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package pygmy_intf_typedef;
    localparam int CPU_TID_W   = 6;
    localparam int SRC_W       = 3;
    localparam int NOC_ID_W    = 2;
    localparam int PADDR_W     = 40;
    localparam int CPU_DATA_W  = 64;
    localparam int CPU_MASK_W  = 8;

    typedef enum logic [1:0] {
        CPU_REQ_LOAD  = 2'd0,
        CPU_REQ_STORE = 2'd1,
        CPU_REQ_AMO   = 2'd2,
        CPU_REQ_FLUSH = 2'd3
    } cpu_req_type_e;

    typedef struct packed {
        logic [NOC_ID_W-1:0]  cpu_noc_id;
        logic [SRC_W-1:0]     src;
        logic [CPU_TID_W-1:0] tid;
    } cpu_cache_if_tid_t;

    typedef struct packed {
        cpu_cache_if_tid_t     req_tid;
        cpu_req_type_e         req_type;
        logic [PADDR_W-1:0]    paddr;
        logic [CPU_DATA_W-1:0] data;
        logic [CPU_MASK_W-1:0] mask;
    } cpu_cache_if_req_t;

    typedef struct packed {
        cpu_cache_if_tid_t     resp_tid;
        logic [CPU_DATA_W-1:0] data;
        logic [CPU_MASK_W-1:0] mask;
    } cpu_cache_if_resp_t;

    // One tracking-table slot: issuer index and the issuer's own tid.
    typedef struct packed {
        logic              valid;
        logic [SRC_W-1:0]  src;
        cpu_cache_if_tid_t orig_tid;
    } usb_rob_ent_t;
endpackage : pygmy_intf_typedef
`default_nettype wire

// File: rtl/usb_rob_tid_table.sv
`default_nettype none
// ============================================================================
// Module      : usb_rob_tid_table
// Description : Transaction tracking table. Holds 2**TID_W entries, reports
//               the lowest free index (from registered valid bits only),
//               writes an entry on allocation and exposes a lookup/clear port.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_alloc_*         - write entry i_alloc_idx
//               o_free_avail/idx  - any free entry / lowest free index
//               i_lookup_idx      - entry read (combinational) and clear index
//               o_lookup_ent      - entry at i_lookup_idx
//               i_clr_en          - invalidate entry i_lookup_idx
// Revision    : 1.0 - initial release
// ============================================================================
module usb_rob_tid_table
    import pygmy_intf_typedef::*;
#(
    parameter int TID_W = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_alloc_en,
    input  wire logic [TID_W-1:0]  i_alloc_idx,
    input  wire logic [SRC_W-1:0]  i_alloc_src,
    input  cpu_cache_if_tid_t      i_alloc_tid,
    output logic                   o_free_avail,
    output logic [TID_W-1:0]       o_free_idx,
    input  wire logic [TID_W-1:0]  i_lookup_idx,
    output usb_rob_ent_t           o_lookup_ent,
    input  wire logic              i_clr_en
);
    localparam int c_n_ent = 2 ** TID_W;

    usb_rob_ent_t r_ent [c_n_ent];

    // Descending scan so the lowest free index wins.
    always_comb begin
        o_free_avail = 1'b0;
        o_free_idx   = '0;
        for (int i = c_n_ent - 1; i >= 0; i--) begin
            if (!r_ent[i].valid) begin
                o_free_avail = 1'b1;
                o_free_idx   = TID_W'(i);
            end
        end
    end

    assign o_lookup_ent = r_ent[i_lookup_idx];

    // Alloc targets a free slot and clear targets a live one, so the two
    // writes never hit the same entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_n_ent; i++) begin
                r_ent[i] <= '0;
            end
        end else begin
            if (i_alloc_en) begin
                r_ent[i_alloc_idx] <= '{valid: 1'b1, src: i_alloc_src, orig_tid: i_alloc_tid};
            end
            if (i_clr_en) begin
                r_ent[i_lookup_idx].valid <= 1'b0;
            end
        end
    end
endmodule : usb_rob_tid_table
`default_nettype wire

// File: rtl/usb_rob_sched.sv
`default_nettype none
// ============================================================================
// Module      : usb_rob_sched
// Description : Schedules N_REQ USB-side requesters onto one cache port.
//               Round-robin arbitration with per-requester credit limits,
//               tracking-table tid allocation, and response routing back to
//               the issuer with its original req_tid restored.
// Ports       : clk, rst                       - clock, sync active-high reset
//               cpu_if_req_valid/req/ready     - upstream request channels
//               cpu_if_resp_valid/resp/ready   - upstream response channels
//               cache_if_req_valid/req/ready   - downstream request
//               cache_if_resp_valid/resp/ready - downstream response
//               outst_cnt                      - live table entries
//               err_unexp_resp                 - pulse: response to dead tid
// Revision    : 1.0 - initial release
// ============================================================================
module usb_rob_sched
    import pygmy_cfg::*;
    import pygmy_intf_typedef::*;
#(
    parameter int N_REQ     = 2,
    parameter int TID_W     = USB_ROB_TID_W,
    parameter int MAX_OUTST = USB_ROB_MAX_OUTST
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic [N_REQ-1:0]         cpu_if_req_valid,
    input  cpu_cache_if_req_t [N_REQ-1:0] cpu_if_req,
    output logic [N_REQ-1:0]              cpu_if_req_ready,
    output logic [N_REQ-1:0]              cpu_if_resp_valid,
    output cpu_cache_if_resp_t [N_REQ-1:0] cpu_if_resp,
    input  wire logic [N_REQ-1:0]         cpu_if_resp_ready,
    output logic                          cache_if_req_valid,
    output cpu_cache_if_req_t             cache_if_req,
    input  wire logic                     cache_if_req_ready,
    input  wire logic                     cache_if_resp_valid,
    input  cpu_cache_if_resp_t            cache_if_resp,
    output logic                          cache_if_resp_ready,
    output logic [TID_W:0]                outst_cnt,
    output logic                          err_unexp_resp
);
    localparam int c_ptr_w = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_cnt_w = $clog2(MAX_OUTST + 1);

    logic [c_ptr_w-1:0]              r_rr_ptr;
    logic [N_REQ-1:0][c_cnt_w-1:0]   r_cnt;
    logic                            r_lock;
    logic [c_ptr_w-1:0]              r_lock_grant;
    logic [TID_W-1:0]                r_lock_tid;
    logic [TID_W:0]                  r_outst_cnt;
    logic                            r_err_unexp;

    logic                            w_free_avail;
    logic [TID_W-1:0]                w_free_idx;
    usb_rob_ent_t                    w_ent;
    logic [N_REQ-1:0]                w_elig;
    logic                            w_arb_found;
    logic [c_ptr_w-1:0]              w_arb_idx;
    logic [c_ptr_w-1:0]              w_grant_idx;
    logic [TID_W-1:0]                w_alloc_idx;
    logic                            w_req_hs;
    logic [TID_W-1:0]                w_resp_idx;
    logic                            w_resp_hs;
    logic                            w_resp_drop;
    logic [N_REQ-1:0]                w_inc;
    logic [N_REQ-1:0]                w_dec;

    usb_rob_tid_table #(
        .TID_W (TID_W)
    ) u_tid_table (
        .clk          (clk),
        .rst          (rst),
        .i_alloc_en   (w_req_hs),
        .i_alloc_idx  (w_alloc_idx),
        .i_alloc_src  (SRC_W'(w_grant_idx)),
        .i_alloc_tid  (cpu_if_req[w_grant_idx].req_tid),
        .o_free_avail (w_free_avail),
        .o_free_idx   (w_free_idx),
        .i_lookup_idx (w_resp_idx),
        .o_lookup_ent (w_ent),
        .i_clr_en     (w_resp_hs)
    );

    // ---------------------------------------------------------------- arbiter
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_elig
        assign w_elig[gi] = cpu_if_req_valid[gi] && w_free_avail &&
                            (r_cnt[gi] < c_cnt_w'(MAX_OUTST));
    end

    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_arb_found && w_elig[(int'(r_rr_ptr) + k) % N_REQ]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = c_ptr_w'((int'(r_rr_ptr) + k) % N_REQ);
            end
        end
    end

    // A stalled request keeps its grant and tid even if a lower entry frees.
    assign w_grant_idx        = r_lock ? r_lock_grant : w_arb_idx;
    assign w_alloc_idx        = r_lock ? r_lock_tid : w_free_idx;
    assign cache_if_req_valid = r_lock | w_arb_found;
    assign w_req_hs           = cache_if_req_valid & cache_if_req_ready;

    always_comb begin
        cache_if_req                    = cpu_if_req[w_grant_idx];
        cache_if_req.req_tid.tid        = CPU_TID_W'(w_alloc_idx);
        cache_if_req.req_tid.src        = SRC_W'(w_grant_idx);
        cache_if_req.req_tid.cpu_noc_id = '0;
    end

    always_comb begin
        cpu_if_req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cpu_if_req_ready[i] = cache_if_req_valid && cache_if_req_ready &&
                                  (w_grant_idx == c_ptr_w'(i));
        end
    end

    // -------------------------------------------------------- response route
    assign w_resp_idx = cache_if_resp.resp_tid.tid[TID_W-1:0];

    always_comb begin
        cpu_if_resp_valid   = '0;
        cpu_if_resp         = '0;
        cache_if_resp_ready = 1'b1;   // dead tids are swallowed
        if (w_ent.valid) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_ent.src == SRC_W'(i)) begin
                    cpu_if_resp_valid[i]     = cache_if_resp_valid;
                    cpu_if_resp[i].resp_tid  = w_ent.orig_tid;
                    cpu_if_resp[i].data      = cache_if_resp.data;
                    cpu_if_resp[i].mask      = cache_if_resp.mask;
                    cache_if_resp_ready      = cpu_if_resp_ready[i];
                end
            end
        end
    end

    assign w_resp_hs   = cache_if_resp_valid & w_ent.valid & cache_if_resp_ready;
    assign w_resp_drop = cache_if_resp_valid & ~w_ent.valid;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_inc[i] = w_req_hs && (w_grant_idx == c_ptr_w'(i));
            w_dec[i] = w_resp_hs && (w_ent.src == SRC_W'(i));
        end
    end

    // ------------------------------------------------------------ state regs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_cnt        <= '0;
            r_lock       <= 1'b0;
            r_lock_grant <= '0;
            r_lock_tid   <= '0;
            r_outst_cnt  <= '0;
            r_err_unexp  <= 1'b0;
        end else begin
            r_err_unexp <= w_resp_drop;

            if (w_req_hs) begin
                r_lock   <= 1'b0;
                r_rr_ptr <= (w_grant_idx == c_ptr_w'(N_REQ - 1)) ? '0
                                                                   : w_grant_idx + 1'b1;
            end else if (cache_if_req_valid) begin
                r_lock       <= 1'b1;
                r_lock_grant <= w_grant_idx;
                r_lock_tid   <= w_alloc_idx;
            end

            for (int i = 0; i < N_REQ; i++) begin
                case ({w_inc[i], w_dec[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + 1'b1;
                    2'b01:   r_cnt[i] <= r_cnt[i] - 1'b1;
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end

            case ({w_req_hs, w_resp_hs})
                2'b10:   r_outst_cnt <= r_outst_cnt + 1'b1;
                2'b01:   r_outst_cnt <= r_outst_cnt - 1'b1;
                default: r_outst_cnt <= r_outst_cnt;
            endcase
        end
    end

    assign outst_cnt      = r_outst_cnt;
    assign err_unexp_resp = r_err_unexp;
endmodule : usb_rob_sched
`default_nettype wire

// File: tb/tb_usb_rob_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_rob_sched
// Description : Directed self-checking bench for usb_rob_sched (4 requesters,
//               16-entry table, 4 credits each).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_rob_sched;
    import pygmy_intf_typedef::*;

    localparam int N_REQ = 4;
    localparam int TID_W = 4;

    logic                           clk = 1'b0;
    logic                           rst;
    logic [N_REQ-1:0]               req_valid;
    cpu_cache_if_req_t [N_REQ-1:0]  req_arr;
    logic [N_REQ-1:0]               req_ready;
    logic [N_REQ-1:0]               resp_valid;
    cpu_cache_if_resp_t [N_REQ-1:0] resp_arr;
    logic [N_REQ-1:0]               resp_ready;
    logic                           c_req_valid;
    cpu_cache_if_req_t              c_req;
    logic                           c_req_ready;
    logic                           c_resp_valid;
    cpu_cache_if_resp_t             c_resp;
    logic                           c_resp_ready;
    logic [TID_W:0]                 outst_cnt;
    logic                           err_unexp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    usb_rob_sched #(
        .N_REQ     (N_REQ),
        .TID_W     (TID_W),
        .MAX_OUTST (4)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .cpu_if_req_valid    (req_valid),
        .cpu_if_req          (req_arr),
        .cpu_if_req_ready    (req_ready),
        .cpu_if_resp_valid   (resp_valid),
        .cpu_if_resp         (resp_arr),
        .cpu_if_resp_ready   (resp_ready),
        .cache_if_req_valid  (c_req_valid),
        .cache_if_req        (c_req),
        .cache_if_req_ready  (c_req_ready),
        .cache_if_resp_valid (c_resp_valid),
        .cache_if_resp       (c_resp),
        .cache_if_resp_ready (c_resp_ready),
        .outst_cnt           (outst_cnt),
        .err_unexp_resp      (err_unexp)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid    = '0;
        c_resp_valid = 1'b0;
        rst          = 1'b1;
        cyc();
        rst          = 1'b0;
    endtask

    function automatic cpu_cache_if_req_t mk_req(input logic [39:0] paddr, input logic [5:0] tid);
        cpu_cache_if_req_t r;
        r                    = '0;
        r.req_type           = CPU_REQ_LOAD;
        r.paddr              = paddr;
        r.req_tid.tid        = tid;
        r.req_tid.cpu_noc_id = 2'b11;
        return r;
    endfunction

    function automatic cpu_cache_if_resp_t mk_resp(input logic [5:0] tid, input logic [63:0] data);
        cpu_cache_if_resp_t r;
        r              = '0;
        r.resp_tid.tid = tid;
        r.data         = data;
        r.mask         = 8'hFF;
        return r;
    endfunction

    initial begin
        cpu_cache_if_tid_t exp_tid;
        rst          = 1'b1;
        req_valid    = '0;
        req_arr      = '0;
        resp_ready   = '1;
        c_req_ready  = 1'b1;
        c_resp_valid = 1'b0;
        c_resp       = '0;
        for (int i = 0; i < N_REQ; i++) req_arr[i] = mk_req(40'h1000 + 40'(i), 6'h10 + 6'(i));
        cyc();
        do_reset();

        // ---- reset state and single request/response
        #1;
        check("rst_outst", 64'(outst_cnt), 64'd0);
        check("rst_err", 64'(err_unexp), 64'd0);
        check("rst_req_valid", 64'(c_req_valid), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        req_arr[0] = mk_req(40'h100, 6'h2A);
        req_valid  = 4'b0001;
        #1;
        check("single_valid", 64'(c_req_valid), 64'd1);
        check("single_tid", 64'(c_req.req_tid.tid), 64'd0);
        check("single_src", 64'(c_req.req_tid.src), 64'd0);
        check("single_noc", 64'(c_req.req_tid.cpu_noc_id), 64'd0);
        check("single_paddr", 64'(c_req.paddr), 64'h100);
        check("single_ready", 64'(req_ready), 64'b0001);
        cyc();
        req_valid = '0;
        check("single_outst", 64'(outst_cnt), 64'd1);
        c_resp       = mk_resp(6'd0, 64'hDEAD_BEEF);
        c_resp_valid = 1'b1;
        resp_ready   = '0;
        #1;
        check("resp_backpressure", 64'(c_resp_ready), 64'd0);
        resp_ready = '1;
        #1;
        exp_tid = req_arr[0].req_tid;
        check("resp_route", 64'(resp_valid), 64'b0001);
        check("resp_tid_restore", 64'(resp_arr[0].resp_tid), 64'(exp_tid));
        check("resp_data", resp_arr[0].data, 64'hDEAD_BEEF);
        check("resp_ready", 64'(c_resp_ready), 64'd1);
        check("resp_idle_data", resp_arr[1].data, 64'd0);
        cyc();
        c_resp_valid = 1'b0;
        check("resp_outst", 64'(outst_cnt), 64'd0);
        check("resp_err", 64'(err_unexp), 64'd0);

        // ---- round robin between req0 and req1
        do_reset();
        req_arr[0] = mk_req(40'h1000, 6'h10);
        req_valid  = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_src", 64'(c_req.req_tid.src), 64'(k % 2));
            check("rr_tid", 64'(c_req.req_tid.tid), 64'(k));
            cyc();
        end
        req_valid = '0;
        check("rr_outst", 64'(outst_cnt), 64'd4);

        // ---- credit limit
        do_reset();
        req_valid = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("cred_tid", 64'(c_req.req_tid.tid), 64'(k));
            cyc();
        end
        req_valid = 4'b0011;
        #1;
        check("cred_ready", 64'(req_ready), 64'b0010);
        check("cred_src1", 64'(c_req.req_tid.src), 64'd1);
        check("cred_tid1", 64'(c_req.req_tid.tid), 64'd4);
        cyc();
        req_valid    = 4'b0001;
        c_resp       = mk_resp(6'd2, 64'h55);
        c_resp_valid = 1'b1;
        #1;
        check("cred_blocked", 64'(c_req_valid), 64'd0);
        check("cred_resp", 64'(resp_valid), 64'b0001);
        cyc();
        c_resp_valid = 1'b0;
        #1;
        check("cred_regrant", 64'(req_ready), 64'b0001);
        check("cred_regrant_tid", 64'(c_req.req_tid.tid), 64'd2);
        cyc();
        req_valid = '0;
        check("cred_outst", 64'(outst_cnt), 64'd5);

        // ---- stall lock
        do_reset();
        req_arr[0]  = mk_req(40'h200, 6'h01);
        req_arr[1]  = mk_req(40'h300, 6'h02);
        req_valid   = 4'b0001;
        c_req_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("lock_valid", 64'(c_req_valid), 64'd1);
            check("lock_src", 64'(c_req.req_tid.src), 64'd0);
            check("lock_tid", 64'(c_req.req_tid.tid), 64'd0);
            check("lock_paddr", 64'(c_req.paddr), 64'h200);
            check("lock_noready", 64'(req_ready), 64'd0);
            cyc();
            req_valid = 4'b0011;
        end
        c_req_ready = 1'b1;
        #1;
        check("lock_hs", 64'(req_ready), 64'b0001);
        check("lock_hs_tid", 64'(c_req.req_tid.tid), 64'd0);
        cyc();
        req_valid = 4'b0010;
        #1;
        check("lock_next_src", 64'(c_req.req_tid.src), 64'd1);
        check("lock_next_tid", 64'(c_req.req_tid.tid), 64'd1);
        check("lock_next_paddr", 64'(c_req.paddr), 64'h300);
        cyc();
        req_valid = '0;
        check("lock_outst", 64'(outst_cnt), 64'd2);

        // ---- fill table, free tid 5 and reuse it
        do_reset();
        for (int i = 0; i < N_REQ; i++) req_arr[i] = mk_req(40'h1000 + 40'(i), 6'h10 + 6'(i));
        req_valid = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            #1;
            check("fill_src", 64'(c_req.req_tid.src), 64'(k % 4));
            check("fill_tid", 64'(c_req.req_tid.tid), 64'(k));
            cyc();
        end
        check("full_outst", 64'(outst_cnt), 64'd16);
        check("full_valid", 64'(c_req_valid), 64'd0);
        c_resp       = mk_resp(6'd5, 64'hA5);
        c_resp_valid = 1'b1;
        #1;
        check("full_resp_route", 64'(resp_valid), 64'b0010);
        check("full_resp_tid", 64'(resp_arr[1].resp_tid.tid), 64'h11);
        check("full_no_req", 64'(c_req_valid), 64'd0);
        cyc();
        c_resp = mk_resp(6'd9, 64'hA9);
        #1;
        check("reuse_src", 64'(c_req.req_tid.src), 64'd1);
        check("reuse_tid", 64'(c_req.req_tid.tid), 64'd5);
        check("reuse_outst", 64'(outst_cnt), 64'd15);
        check("reuse_resp9", 64'(resp_valid), 64'b0010);
        cyc();
        c_resp_valid = 1'b0;
        check("swap_outst", 64'(outst_cnt), 64'd15);
        #1;
        check("reuse9_tid", 64'(c_req.req_tid.tid), 64'd9);
        cyc();
        req_valid = '0;
        check("refill_outst", 64'(outst_cnt), 64'd16);

        // ---- unexpected response and reset discard
        do_reset();
        c_resp       = mk_resp(6'd9, 64'h99);
        c_resp_valid = 1'b1;
        #1;
        check("unexp_ready", 64'(c_resp_ready), 64'd1);
        check("unexp_no_valid", 64'(resp_valid), 64'd0);
        check("unexp_err_early", 64'(err_unexp), 64'd0);
        cyc();
        c_resp_valid = 1'b0;
        check("unexp_err", 64'(err_unexp), 64'd1);
        cyc();
        check("unexp_err_clr", 64'(err_unexp), 64'd0);
        req_valid = 4'b0001;
        repeat (3) cyc();
        req_valid = '0;
        check("pre_rst_outst", 64'(outst_cnt), 64'd3);
        do_reset();
        check("post_rst_outst", 64'(outst_cnt), 64'd0);
        c_resp       = mk_resp(6'd1, 64'h11);
        c_resp_valid = 1'b1;
        #1;
        check("stale_no_valid", 64'(resp_valid), 64'd0);
        cyc();
        c_resp_valid = 1'b0;
        check("stale_err", 64'(err_unexp), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule : tb_usb_rob_sched
`default_nettype wire
